insertion_sort_ctrl: RTL
========================

// Module: insertion_sort_ctrl
// PURPOSE
//  FSM controller that runs insertion sort on `datapath`: drives its load/clear/select strobes, consumes its compare flags.
//  Owns the memory valid/ready handshakes: AR/R read channels, AW/W/B write channels.
//  Sits between top-level start/done and `datapath`; array memory is external.
// PARAMETERS
//  ADDR_WDTH  4  address width; must match datapath
//  RESP_WDTH  1  write-response width; any nonzero b_resp = error
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  begin sort of arr_size words at 0..arr_size-1; sampled in IDLE only
//  busy         out  1  high from accepted start until DONE/ERR
//  done         out  1  one-cycle pulse when sort completes
//  error        out  1  sticky; set on bad b_resp, cleared by next accepted start
//  ar_valid/ar_ready  out/in  1  read address handshake; address comes from datapath
//  r_valid/r_ready    in/out  1  read data handshake
//  aw_valid/aw_ready  out/in  1  write address handshake
//  w_valid/w_ready    out/in  1  write data handshake
//  b_valid/b_ready    in/out  1  write response handshake
//  b_resp       in   RESP_WDTH  write response, 0 = OKAY
//  elem2insert_gt_elem2compare, j_gte_0, i_lt_arr_size  in  1  datapath flags
//  sl_1_incd_to_i, ld_i, clr_i  out 1  i control; sel 0=const 1, 1=i+1
//  sl_i_minus_1_decrd_to_j, ld_j, clr_j  out 1  j control; sel 0=i-1, 1=j-1
//  ld_elem2insert, clr_elem2insert, ld_elem2compare, clr_elem2compare  out 1  data regs
//  sl_i_j_to_arr_ra  out 1  read addr; 0=i, 1=j
//  sl_j_j_plus_1_to_arr_wa  out 1  write addr; 0=j, 1=j+1
//  sl_elem2insert_elem2compare_to_arr_w  out 1  write data; 0=elem2insert, 1=elem2compare
// BEHAVIOUR
//  Reset: state IDLE; every output 0; error 0. Reset mid-sort aborts at once: valids drop, memory contents undefined.
//  Datapath registers load on the edge ending a cycle with ld_*; flags are combinational from registers.
//  States and transitions:
//   IDLE  -start-> INIT : clr_i, clr_j, clr_elem2insert, clr_elem2compare, clear error.
//   INIT  : ld_i with sel=1 (i=1)                                       -> CHK_I
//   CHK_I : i_lt_arr_size ? RD_KEY : DONE   (arr_size 0/1 finish with zero memory transactions)
//   RD_KEY: ra=i; ar_valid until ar_ready, then r_ready; ld_elem2insert in the r_valid&r_ready cycle -> SET_J
//   SET_J : ld_j, sel=0 (j=i-1)                                         -> CHK_J
//   CHK_J : j_gte_0 ? RD_CMP : INSERT
//   RD_CMP: ra=j; same read handshake; ld_elem2compare                  -> CMP
//   CMP   : elem2insert_gt_elem2compare ? INSERT : SHIFT   (equal keys shift: not stable)
//   SHIFT : write a[j+1]=elem2compare (wa=1, wdata=1)                    -> DEC_J
//   DEC_J : ld_j, sel=1 (j=j-1)                                         -> CHK_J
//   INSERT: write a[j+1]=elem2insert (wa=1, wdata=0)                     -> INC_I
//   INC_I : ld_i, sel=1                                                 -> CHK_I
//   DONE  : done=1 for one cycle, busy=0                                 -> IDLE
//   ERR   : busy=0, error held                                           -> IDLE
//  Read rule: ar_valid rises the cycle after state entry; held until ar_ready; ar_ready alone is ignored.
//   r_ready is high only after AR is accepted. R may complete no earlier than the cycle after AR.
//  Write rule: aw_valid and w_valid rise together; each drops independently on its own ready.
//   After both are accepted, b_ready=1 until b_valid. b_resp!=0 sets error -> ERR. Selects are held stable during the whole transaction.
//  Latency with ready/valid always 1: read 2 cycles, write 2 cycles, plus 1 cycle per bookkeeping state.
//  start while busy: ignored. arr_size is sampled by the datapath, so it must stay stable while busy.
//  j underflow: j_gte_0 goes low when j wraps to -1 (ADDR_WDTH+1-bit signed register); handled by CHK_J.
// STRUCTURE
//  sort_ctrl_defs.vh: state encodings (localparam) and select-value constants (SEL_I_ONE, SEL_J_DEC, ...).
//   Shared with datapath and tests.
//  Sub-module mem_wr_txn: AW/W/B tracking.
//   Inputs: go. Outputs: aw_done/w_done flags, b_ready, busy, ok/err pulse.
//   Instantiated once. The read handshake stays inline.
// TESTING
//  1. arr_size=4, mem {3,1,2,0}, all readies=1 -> mem {0,1,2,3}; done pulses once; error=0.
//  2. arr_size=1 -> done within 4 cycles of start; no ar_valid or aw_valid seen.
//  3. Sorted {1,2,3,4} -> exactly 3 key reads, 3 compare reads, 3 inserts, 0 shifts.
//  4. Random 0-3 cycle stalls on all readies and on r_valid/b_valid; {9,9,5,7} -> {5,7,9,9}.
//     Assert valid held to ready and selects stable during each transaction.
//  5. b_resp=1 on the first write -> error=1, FSM in IDLE, busy=0, no done. Next start clears error.
//  6. rst pulsed while aw_valid high mid-sort -> next cycle all outputs 0, state IDLE.
//     A fresh start sorts {2,1} -> {1,2}.

Source files
------------

// File: rtl/insertion_sort_ctrl_pkg.sv
// rtl/insertion_sort_ctrl_pkg.sv - state encoding and datapath select values for insertion_sort_ctrl
package insertion_sort_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_INIT   = 4'd1,
      ST_CHK_I  = 4'd2,
      ST_RD_KEY = 4'd3,
      ST_SET_J  = 4'd4,
      ST_CHK_J  = 4'd5,
      ST_RD_CMP = 4'd6,
      ST_CMP    = 4'd7,
      ST_SHIFT  = 4'd8,
      ST_DEC_J  = 4'd9,
      ST_INSERT = 4'd10,
      ST_INC_I  = 4'd11,
      ST_DONE   = 4'd12,
      ST_ERR    = 4'd13
   } state_t;

   // i source: constant 1 or i+1
   localparam logic SEL_I_ONE  = 1'b0;
   localparam logic SEL_I_INC  = 1'b1;
   // j source: i-1 or j-1
   localparam logic SEL_J_IM1  = 1'b0;
   localparam logic SEL_J_DEC  = 1'b1;
   // read address: i or j
   localparam logic SEL_RA_I   = 1'b0;
   localparam logic SEL_RA_J   = 1'b1;
   // write address: j or j+1
   localparam logic SEL_WA_J   = 1'b0;
   localparam logic SEL_WA_J1  = 1'b1;
   // write data: elem2insert or elem2compare
   localparam logic SEL_WD_KEY = 1'b0;
   localparam logic SEL_WD_CMP = 1'b1;

   function automatic logic is_read_state(input state_t s);
      return (s == ST_RD_KEY) || (s == ST_RD_CMP);
   endfunction

   function automatic logic is_write_state(input state_t s);
      return (s == ST_SHIFT) || (s == ST_INSERT);
   endfunction

endpackage

// File: rtl/insertion_sort_ctrl_mem_wr_txn.sv
// rtl/insertion_sort_ctrl_mem_wr_txn.sv - one memory write transaction over independent AW/W channels and B response
module mem_wr_txn #(
   parameter int RESP_WDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   output logic                 aw_valid,
   input  logic                 aw_ready,
   output logic                 w_valid,
   input  logic                 w_ready,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [RESP_WDTH-1:0] b_resp,
   output logic                 aw_done,
   output logic                 w_done,
   output logic                 busy,
   output logic                 ok,
   output logic                 err
);

   logic active_q,   active_d;
   logic aw_valid_q, aw_valid_d;
   logic w_valid_q,  w_valid_d;
   logic b_ready_q,  b_ready_d;
   logic b_hs;

   // AW and W drop on their own ready; B is awaited once both have been accepted
   always_comb begin
      b_hs       = b_ready_q & b_valid;
      aw_valid_d = go | (aw_valid_q & ~aw_ready);
      w_valid_d  = go | (w_valid_q & ~w_ready);
      active_d   = go | (active_q & ~b_hs);
      b_ready_d  = (b_ready_q & ~b_valid)
                 | (active_q & ~b_ready_q & ~aw_valid_d & ~w_valid_d);
   end

   // transaction registers, cleared immediately on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q   <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
      end else begin
         active_q   <= active_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
      end
   end

   assign aw_valid = aw_valid_q;
   assign w_valid  = w_valid_q;
   assign b_ready  = b_ready_q;
   assign aw_done  = active_q & ~aw_valid_q;
   assign w_done   = active_q & ~w_valid_q;
   assign busy     = active_q;
   assign ok       = b_hs & (b_resp == '0);
   assign err      = b_hs & (b_resp != '0);

endmodule

// File: rtl/insertion_sort_ctrl.sv
// rtl/insertion_sort_ctrl.sv - insertion sort sequencer driving datapath strobes and memory handshakes
module insertion_sort_ctrl #(
   parameter int ADDR_WDTH = 4,
   parameter int RESP_WDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 ar_valid,
   input  logic                 ar_ready,
   input  logic                 r_valid,
   output logic                 r_ready,
   output logic                 aw_valid,
   input  logic                 aw_ready,
   output logic                 w_valid,
   input  logic                 w_ready,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [RESP_WDTH-1:0] b_resp,
   input  logic                 elem2insert_gt_elem2compare,
   input  logic                 j_gte_0,
   input  logic                 i_lt_arr_size,
   output logic                 sl_1_incd_to_i,
   output logic                 ld_i,
   output logic                 clr_i,
   output logic                 sl_i_minus_1_decrd_to_j,
   output logic                 ld_j,
   output logic                 clr_j,
   output logic                 ld_elem2insert,
   output logic                 clr_elem2insert,
   output logic                 ld_elem2compare,
   output logic                 clr_elem2compare,
   output logic                 sl_i_j_to_arr_ra,
   output logic                 sl_j_j_plus_1_to_arr_wa,
   output logic                 sl_elem2insert_elem2compare_to_arr_w
);

   import insertion_sort_ctrl_pkg::*;

   state_t state_q, state_d;
   logic   ar_valid_q, ar_valid_d;
   logic   r_ready_q,  r_ready_d;
   logic   error_q,    error_d;
   logic   rd_hs;
   logic   enter_rd;
   logic   wr_go;
   logic   wr_ok, wr_err, wr_busy;
   logic   wr_aw_done, wr_w_done;
   logic   start_acc;

   // Per-channel progress flags and the address width are not needed by the sequencing logic
   logic   unused_wr_flags;
   assign unused_wr_flags = ^{wr_aw_done, wr_w_done, ADDR_WDTH[0]};

   assign rd_hs     = r_valid & r_ready_q;
   assign start_acc = (state_q == ST_IDLE) & start;
   assign enter_rd  = is_read_state(state_d) & (state_d != state_q);
   assign wr_go     = is_write_state(state_d) & (state_d != state_q) & ~wr_busy;

   mem_wr_txn #(
      .RESP_WDTH (RESP_WDTH)
   ) u_wr (
      .clk      (clk),
      .rst      (rst),
      .go       (wr_go),
      .aw_valid (aw_valid),
      .aw_ready (aw_ready),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_resp   (b_resp),
      .aw_done  (wr_aw_done),
      .w_done   (wr_w_done),
      .busy     (wr_busy),
      .ok       (wr_ok),
      .err      (wr_err)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic: memory states wait on their handshake, bookkeeping states take one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_INIT;
         ST_INIT:   state_d = ST_CHK_I;
         ST_CHK_I:  state_d = i_lt_arr_size ? ST_RD_KEY : ST_DONE;
         ST_RD_KEY: if (rd_hs) state_d = ST_SET_J;
         ST_SET_J:  state_d = ST_CHK_J;
         ST_CHK_J:  state_d = j_gte_0 ? ST_RD_CMP : ST_INSERT;
         ST_RD_CMP: if (rd_hs) state_d = ST_CMP;
         ST_CMP:    state_d = elem2insert_gt_elem2compare ? ST_INSERT : ST_SHIFT;
         ST_SHIFT: begin
            if (wr_err)     state_d = ST_ERR;
            else if (wr_ok) state_d = ST_DEC_J;
         end
         ST_DEC_J:  state_d = ST_CHK_J;
         ST_INSERT: begin
            if (wr_err)     state_d = ST_ERR;
            else if (wr_ok) state_d = ST_INC_I;
         end
         ST_INC_I:  state_d = ST_CHK_I;
         ST_DONE:   state_d = ST_IDLE;
         ST_ERR:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // read handshake and sticky error next-state
   always_comb begin
      ar_valid_d = enter_rd | (ar_valid_q & ~ar_ready);
      r_ready_d  = (ar_valid_q & ar_ready) | (r_ready_q & ~r_valid);
      error_d    = error_q;
      if (start_acc)   error_d = 1'b0;
      else if (wr_err) error_d = 1'b1;
   end

   // read handshake and error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
         error_q    <= error_d;
      end
   end

   // output decode: strobes and selects per state; selects stay constant for the whole state
   always_comb begin
      busy                                 = 1'b0;
      done                                 = 1'b0;
      sl_1_incd_to_i                       = SEL_I_ONE;
      ld_i                                 = 1'b0;
      clr_i                                = 1'b0;
      sl_i_minus_1_decrd_to_j              = SEL_J_IM1;
      ld_j                                 = 1'b0;
      clr_j                                = 1'b0;
      ld_elem2insert                       = 1'b0;
      clr_elem2insert                      = 1'b0;
      ld_elem2compare                      = 1'b0;
      clr_elem2compare                     = 1'b0;
      sl_i_j_to_arr_ra                     = SEL_RA_I;
      sl_j_j_plus_1_to_arr_wa              = SEL_WA_J;
      sl_elem2insert_elem2compare_to_arr_w = SEL_WD_KEY;
      case (state_q)
         ST_IDLE: begin
            clr_i            = start;
            clr_j            = start;
            clr_elem2insert  = start;
            clr_elem2compare = start;
         end
         ST_INIT: begin
            busy           = 1'b1;
            ld_i           = 1'b1;
            sl_1_incd_to_i = SEL_I_INC;
         end
         ST_RD_KEY: begin
            busy             = 1'b1;
            sl_i_j_to_arr_ra = SEL_RA_I;
            ld_elem2insert   = rd_hs;
         end
         ST_SET_J: begin
            busy                    = 1'b1;
            ld_j                    = 1'b1;
            sl_i_minus_1_decrd_to_j = SEL_J_IM1;
         end
         ST_RD_CMP: begin
            busy             = 1'b1;
            sl_i_j_to_arr_ra = SEL_RA_J;
            ld_elem2compare  = rd_hs;
         end
         ST_SHIFT: begin
            busy                                 = 1'b1;
            sl_j_j_plus_1_to_arr_wa              = SEL_WA_J1;
            sl_elem2insert_elem2compare_to_arr_w = SEL_WD_CMP;
         end
         ST_DEC_J: begin
            busy                    = 1'b1;
            ld_j                    = 1'b1;
            sl_i_minus_1_decrd_to_j = SEL_J_DEC;
         end
         ST_INSERT: begin
            busy                                 = 1'b1;
            sl_j_j_plus_1_to_arr_wa              = SEL_WA_J1;
            sl_elem2insert_elem2compare_to_arr_w = SEL_WD_KEY;
         end
         ST_INC_I: begin
            busy           = 1'b1;
            ld_i           = 1'b1;
            sl_1_incd_to_i = SEL_I_INC;
         end
         ST_DONE:  done = 1'b1;
         ST_ERR:   busy = 1'b0;
         default:  busy = (state_q != ST_IDLE);
      endcase
   end

   assign ar_valid = ar_valid_q;
   assign r_ready  = r_ready_q;
   assign error    = error_q;

endmodule
